// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use, control and dmem waits.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter output.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] if_id_rs_i,
  input  logic [REG_AW-1:0] if_id_rt_i,
  input  logic [REG_AW-1:0] id_ex_rt_i,
  input  logic              id_ex_memread_i,
  input  logic              jump_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_hold_o,
  output logic              mem_err_o,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    A_DEF,
    A_RST,
    A_FRZ,
    A_BR,
    A_STL,
    A_JMP,
    A_HALT
  } act_t;

  localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);
  localparam bit         MULTI    = LOAD_BUBBLES > 1;

  state_t     state;
  logic [2:0] bub_cnt;
  logic [7:0] wait_cnt;
  logic       mem_err;
  act_t       act;

  logic memwait;
  logic mem_done;
  logic lu;
  logic bub_pend;
  logic rs_hit;
  logic rt_hit;

  assign memwait  = dmem_req_i & ~dmem_ready_i;
  assign mem_done = dmem_req_i & dmem_ready_i;
  assign rs_hit   = id_ex_rt_i == if_id_rs_i;
  assign rt_hit   = id_ex_rt_i == if_id_rt_i;
  assign lu       = id_ex_memread_i & (id_ex_rt_i != '0)
                  & (rs_hit | rt_hit);
  assign bub_pend = bub_cnt != 3'd0;

  assign mem_err_o = mem_err;
  assign state_o   = state;

  always_comb begin
    act = A_DEF;
    if (rst_i) begin
      act = A_RST;
    end else begin
      unique case (state)
        RUN: begin
          if (memwait)             act = A_FRZ;
          else if (branch_taken_i) act = A_BR;
          else if (lu)             act = A_STL;
          else if (jump_i)         act = A_JMP;
        end
        LU_STALL: begin
          if (memwait)             act = A_FRZ;
          else if (branch_taken_i) act = A_BR;
          else                     act = A_STL;
        end
        MEM_WAIT: begin
          if (!mem_done)           act = A_FRZ;
          else if (branch_taken_i) act = A_BR;
          else if (lu | bub_pend)  act = A_STL;
          else if (jump_i)         act = A_JMP;
        end
        ERR: act = A_HALT;
      endcase
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_hold_o  = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_mem_hold_o = 1'b0;
    unique case (act)
      A_DEF: ;
      A_RST: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      A_FRZ, A_HALT: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_hold_o  = 1'b1;
        ex_mem_hold_o = 1'b1;
      end
      A_BR: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      A_STL: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
      end
      A_JMP: if_id_flush_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      bub_cnt  <= 3'd0;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (memwait) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (branch_taken_i) begin
            state <= RUN;
          end else if (lu && MULTI) begin
            state   <= LU_STALL;
            bub_cnt <= BUB_INIT;
          end
        end
        LU_STALL: begin
          if (memwait) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (branch_taken_i || bub_cnt <= 3'd1) begin
            state   <= RUN;
            bub_cnt <= 3'd0;
          end else begin
            bub_cnt <= bub_cnt - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            wait_cnt <= 8'd0;
            // the ready cycle itself issues one of the pending bubbles
            if (branch_taken_i || (bub_pend && bub_cnt <= 3'd1)) begin
              state   <= RUN;
              bub_cnt <= 3'd0;
            end else if (bub_pend) begin
              state   <= LU_STALL;
              bub_cnt <= bub_cnt - 3'd1;
            end else if (lu && MULTI) begin
              state   <= LU_STALL;
              bub_cnt <= BUB_INIT;
            end else begin
              state <= RUN;
            end
          end else if (wait_cnt >= WAIT_MAX) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR: state <= ERR;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= 32'd0;
    end else if (!pc_write_o && perf_stall_cnt_o != '1) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_BUBBLES=1 and 3/MEM_TIMEOUT=8).
// Control pattern order: {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold}.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] P_DEF = 6'b110000;
  localparam logic [5:0] P_RST = 6'b001010;
  localparam logic [5:0] P_FRZ = 6'b000101;
  localparam logic [5:0] P_BR  = 6'b111010;
  localparam logic [5:0] P_STL = 6'b000010;
  localparam logic [5:0] P_JMP = 6'b111000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, ex_rt;
  logic       memread, jump, branch, req, ready;

  logic       a_pcw, a_ifw, a_iff, a_idh, a_idf, a_exh, a_err;
  logic       b_pcw, b_ifw, b_iff, b_idh, b_idf, b_exh, b_err;
  logic [1:0] a_st, b_st;
  logic [5:0] a_pat, b_pat;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_perf, b_perf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign a_pat = {a_pcw, a_ifw, a_iff, a_idh, a_idf, a_exh};
  assign b_pat = {b_pcw, b_ifw, b_iff, b_idh, b_idf, b_exh};

  pipe_hazard_ctrl u_a (
    .clk_i(clk), .rst_i(rst),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .id_ex_rt_i(ex_rt),
    .id_ex_memread_i(memread), .jump_i(jump),
    .branch_taken_i(branch), .dmem_req_i(req), .dmem_ready_i(ready),
    .pc_write_o(a_pcw), .if_id_write_o(a_ifw), .if_id_flush_o(a_iff),
    .id_ex_hold_o(a_idh), .id_ex_flush_o(a_idf), .ex_mem_hold_o(a_exh),
    .mem_err_o(a_err), .state_o(a_st)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt_o(a_perf)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .id_ex_rt_i(ex_rt),
    .id_ex_memread_i(memread), .jump_i(jump),
    .branch_taken_i(branch), .dmem_req_i(req), .dmem_ready_i(ready),
    .pc_write_o(b_pcw), .if_id_write_o(b_ifw), .if_id_flush_o(b_iff),
    .id_ex_hold_o(b_idh), .id_ex_flush_o(b_idf), .ex_mem_hold_o(b_exh),
    .mem_err_o(b_err), .state_o(b_st)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt_o(b_perf)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; ex_rt = 5'd0;
    memread = 0; jump = 0; branch = 0; req = 0; ready = 0;
  endtask

  task automatic set_lu();
    memread = 1; ex_rt = 5'd2; rs = 5'd2; rt = 5'd5;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    cyc(); cyc();
    #2;
    n_chk++;
    if (a_pat !== P_RST) begin
      n_fail++; $display("FAIL rst_pat_a got %b want %b", a_pat, P_RST);
    end
    n_chk++;
    if ({b_st, b_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_state_b got %b want 000", {b_st, b_err});
    end
    cyc();
    rst = 0;
    #2;
    n_chk++;
    if (b_pat !== P_DEF || a_pat !== P_DEF) begin
      n_fail++; $display("FAIL rst_release got %b/%b want %b", a_pat, b_pat, P_DEF);
    end
    cyc();
  endtask

  task automatic test_load_use();
    set_lu();
    #2;
    n_chk++;
    if ({a_pat, b_pat, b_st} !== {P_STL, P_STL, 2'd0}) begin
      n_fail++; $display("FAIL lu_t0 got %b %b st%0d want %b", a_pat, b_pat, b_st, P_STL);
    end
    cyc();
    idle();
    #2;
    n_chk++;
    if (a_pat !== P_DEF) begin
      n_fail++; $display("FAIL lu1_done got %b want %b", a_pat, P_DEF);
    end
    n_chk++;
    if ({b_pat, b_st} !== {P_STL, 2'd1}) begin
      n_fail++; $display("FAIL lu3_t1 got %b st%0d want %b st1", b_pat, b_st, P_STL);
    end
    cyc();
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_STL, 2'd1}) begin
      n_fail++; $display("FAIL lu3_t2 got %b st%0d want %b st1", b_pat, b_st, P_STL);
    end
    cyc();
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_DEF, 2'd0}) begin
      n_fail++; $display("FAIL lu3_t3 got %b st%0d want %b st0", b_pat, b_st, P_DEF);
    end
    // rt-field match on the LOAD_BUBBLES=1 instance only (b resets afterwards)
    memread = 1; ex_rt = 5'd7; rs = 5'd1; rt = 5'd7;
    #2;
    n_chk++;
    if (a_pat !== P_STL) begin
      n_fail++; $display("FAIL lu_rt_match got %b want %b", a_pat, P_STL);
    end
    idle();
    rst = 1;
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_zero_reg();
    memread = 1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
    #2;
    n_chk++;
    if ({a_pat, b_pat} !== {P_DEF, P_DEF}) begin
      n_fail++; $display("FAIL zero_reg got %b %b want %b", a_pat, b_pat, P_DEF);
    end
    cyc();
    idle();
  endtask

  task automatic test_branch_in_stall();
    set_lu();
    cyc();
    idle();
    branch = 1;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_BR, 2'd1}) begin
      n_fail++; $display("FAIL br_stall got %b st%0d want %b st1", b_pat, b_st, P_BR);
    end
    cyc();
    branch = 0;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_DEF, 2'd0}) begin
      n_fail++; $display("FAIL br_stall_next got %b st%0d want %b st0", b_pat, b_st, P_DEF);
    end
    cyc();
  endtask

  task automatic test_mem_wait();
    req = 1; ready = 0;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_FRZ, 2'd0}) begin
      n_fail++; $display("FAIL mw_t0 got %b st%0d want %b st0", b_pat, b_st, P_FRZ);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      #2;
      n_chk++;
      if ({a_pat, a_st, b_pat, b_st} !== {P_FRZ, 2'd2, P_FRZ, 2'd2}) begin
        n_fail++; $display("FAIL mw_t%0d got %b st%0d %b st%0d want %b st2", k, a_pat, a_st, b_pat, b_st, P_FRZ);
      end
    end
    cyc();
    ready = 1;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_DEF, 2'd2}) begin
      n_fail++; $display("FAIL mw_ready got %b st%0d want %b st2", b_pat, b_st, P_DEF);
    end
    cyc();
    idle();
    #2;
    n_chk++;
    if ({a_st, b_st, a_pat} !== {2'd0, 2'd0, P_DEF}) begin
      n_fail++; $display("FAIL mw_exit got st%0d/%0d %b want st0 %b", a_st, b_st, a_pat, P_DEF);
    end
    ready = 1;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_DEF, 2'd0}) begin
      n_fail++; $display("FAIL ready_no_req got %b st%0d want %b st0", b_pat, b_st, P_DEF);
    end
    cyc();
    idle();
  endtask

  task automatic test_jump_combo();
    jump = 1;
    #2;
    n_chk++;
    if (a_pat !== P_JMP) begin
      n_fail++; $display("FAIL jump_only got %b want %b", a_pat, P_JMP);
    end
    branch = 1;
    set_lu();
    #2;
    n_chk++;
    if ({a_pat, b_pat} !== {P_BR, P_BR}) begin
      n_fail++; $display("FAIL jmp_br_lu got %b %b want %b", a_pat, b_pat, P_BR);
    end
    cyc();
    idle();
    #2;
    n_chk++;
    if ({b_st, b_pat} !== {2'd0, P_DEF}) begin
      n_fail++; $display("FAIL jmp_br_lu_next got st%0d %b want st0 %b", b_st, b_pat, P_DEF);
    end
    cyc();
  endtask

  task automatic test_lu_memwait();
    int budget;
    set_lu();
    cyc();
    idle();
    req = 1;
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_FRZ, 2'd1}) begin
      n_fail++; $display("FAIL lumw_t1 got %b st%0d want %b st1", b_pat, b_st, P_FRZ);
    end
    cyc();
    #2;
    n_chk++;
    if ({b_pat, b_st} !== {P_FRZ, 2'd2}) begin
      n_fail++; $display("FAIL lumw_t2 got %b st%0d want %b st2", b_pat, b_st, P_FRZ);
    end
    ready = 1;
    cyc();
    idle();
    #2;
    n_chk++;
    if (b_st !== 2'd1) begin
      n_fail++; $display("FAIL lumw_resume got st%0d want st1", b_st);
    end
    budget = 0;
    while (b_st !== 2'd0 && budget < 10) begin
      cyc();
      budget++;
    end
    n_chk++;
    if (b_st !== 2'd0) begin
      n_fail++; $display("FAIL lumw_drain got st%0d want st0", b_st);
    end
    cyc();
  endtask

  task automatic test_timeout();
    req = 1; ready = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      #2;
      n_chk++;
      if ({b_st, b_err} !== {2'd2, 1'b0}) begin
        n_fail++; $display("FAIL to_wait%0d got st%0d err%b want st2 err0", k, b_st, b_err);
      end
    end
    cyc();
    req = 0;
    #2;
    n_chk++;
    if ({b_st, b_err, b_pat} !== {2'd3, 1'b1, P_FRZ}) begin
      n_fail++; $display("FAIL to_err got st%0d err%b %b want st3 err1 %b", b_st, b_err, b_pat, P_FRZ);
    end
    n_chk++;
    if ({a_st, a_err} !== {2'd2, 1'b0}) begin
      n_fail++; $display("FAIL to_a_wait got st%0d err%b want st2 err0", a_st, a_err);
    end
    cyc();
    #2;
    n_chk++;
    if ({b_st, b_err} !== {2'd3, 1'b1}) begin
      n_fail++; $display("FAIL to_sticky got st%0d err%b want st3 err1", b_st, b_err);
    end
    rst = 1;
    cyc();
    rst = 0;
    #2;
    n_chk++;
    if ({b_st, b_err, b_pat, a_st} !== {2'd0, 1'b0, P_DEF, 2'd0}) begin
      n_fail++; $display("FAIL to_reset got st%0d err%b %b a_st%0d want st0 err0 %b", b_st, b_err, b_pat, a_st, P_DEF);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_in_stall();
    test_mem_wait();
    test_jump_combo();
    test_lu_memwait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipeline CPU.
- Drives the write-enable, hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes: load-use, taken branch / jump control hazards, and multi-cycle data-memory waits.
- Inserts bubbles by zeroing ID/EX control fields and freezes the pipeline while memory is busy.

Parameters:
- REG_AW, 5: register address width.
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before mem_err_o is raised (fits in 8 bits).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_id_rs_i  in  REG_AW  rs field of the instruction in ID.
- if_id_rt_i  in  REG_AW  rt field of the instruction in ID.
- id_ex_rt_i  in  REG_AW  destination (rt) of the instruction in EX.
- id_ex_memread_i  in  1  instruction in EX is a load.
- jump_i  in  1  jump decoded in ID.
- branch_taken_i  in  1  branch resolved taken in EX.
- dmem_req_i  in  1  MEM stage issues a data-memory access.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- if_id_write_o  out  1  IF/ID load enable.
- if_id_flush_o  out  1  IF/ID clear (NOP).
- id_ex_hold_o  out  1  ID/EX keeps its contents.
- id_ex_flush_o  out  1  ID/EX control fields cleared (bubble).
- ex_mem_hold_o  out  1  EX/MEM keeps its contents.
- mem_err_o  out  1  sticky memory-timeout error.
- state_o  out  2  current FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2, ERR=3).

Behaviour:
- Registered state: state, bubble counter (3 bits), wait counter (8 bits), mem_err.
- Outputs are combinational from the current state and inputs (Mealy), so stalls take effect in the same cycle as detection.
- Reset (rst_i=1 at posedge):
  - state=RUN, both counters=0, mem_err_o=0.
  - While rst_i is high, outputs are forced: pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_flush_o=1, id_ex_hold_o=0, ex_mem_hold_o=0.
- Default outputs when no hazard: pc_write_o=1, if_id_write_o=1, all flushes and holds 0.
- Hazard definitions:
  - memwait = dmem_req_i & ~dmem_ready_i.
  - lu = id_ex_memread_i & (id_ex_rt_i!=0) & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
- Priority, highest first: memwait > branch_taken_i > lu or LU_STALL > jump_i.
- RUN:
  - memwait: pc_write_o=0, if_id_write_o=0, id_ex_hold_o=1, ex_mem_hold_o=1, no flushes. Next state MEM_WAIT, wait counter=1.
  - branch_taken_i: pc_write_o=1, if_id_flush_o=1, id_ex_flush_o=1. Stay in RUN.
  - lu: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1. If LOAD_BUBBLES>1, next state LU_STALL with bubble counter=LOAD_BUBBLES-1; otherwise stay in RUN.
  - jump_i alone: if_id_flush_o=1, pc_write_o=1.
- LU_STALL:
  - Same outputs as lu.
  - Bubble counter decrements each cycle; returns to RUN when the counter reaches 1.
  - branch_taken_i takes priority: branch flush outputs, counter cleared, next state RUN.
  - memwait takes priority: enter MEM_WAIT and keep the bubble counter, then resume LU_STALL on exit.
- MEM_WAIT:
  - Freeze outputs as in RUN memwait.
  - Wait counter increments each cycle.
  - dmem_ready_i=1: outputs return to defaults this cycle (branch and lu are evaluated normally). Next state RUN, or LU_STALL if the bubble counter is nonzero.
  - Wait counter reaches MEM_TIMEOUT with dmem_ready_i=0: next state ERR.
- ERR:
  - mem_err_o=1, held until reset.
  - Full freeze: pc_write_o=0, if_id_write_o=0, both holds=1.
  - Exits only via rst_i.
- dmem_ready_i without dmem_req_i is ignored.
- A branch and a jump in the same cycle resolve as the branch: the jump in ID is squashed by if_id_flush_o.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds output perf_stall_cnt_o (32 bits): a saturating count of cycles with pc_write_o=0, excluding reset cycles. Cleared by rst_i.
- When undefined, the port and its counter are absent.

Test Plan:
- Load-use: lw $2 in EX (id_ex_memread_i=1, id_ex_rt_i=2), ID rs=2 -> one cycle pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, then defaults. With LOAD_BUBBLES=3 -> three such cycles, state_o=1 for the last two.
- id_ex_rt_i=0 with a matching rs=0 -> no stall.
- branch_taken_i=1 during LU_STALL (LOAD_BUBBLES=3, second bubble) -> if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; next cycle state_o=0.
- dmem_req_i=1 with dmem_ready_i low for 4 cycles -> state_o=2 and holds=1 for 4 cycles; ready cycle gives defaults, state_o=0 next.
- dmem_req_i=1, ready never arrives, MEM_TIMEOUT=8 -> state_o=3 and mem_err_o=1 after 8 wait cycles; rst_i pulse -> state_o=0, mem_err_o=0.
- jump_i=1 with branch_taken_i=1 and lu=1 in the same cycle -> branch flush pattern only, no stall.
